// File: rtl/lsu_mem_responder_if.sv
// Data-memory bus between the LSU responder and the core data-memory arbiter.
// The responder is the master: it issues req/addr/we/be/wdata and receives
// gnt, rvalid, rdata and err from the memory side.
interface lsu_mem_responder_if;
  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );
endinterface

// File: rtl/lsu_mem_responder.sv
// Responder end of the accelerator LSU request interface. Takes one read or
// write at a time from the accelerator, performs it on the data-memory bus
// with req/gnt/rvalid handshaking and returns a one-cycle lsu_done pulse with
// lane-extracted, zero-extended read data. Misaligned or illegal-type
// requests complete with an error without touching the bus; a watchdog ends
// accesses whose response never arrives.
module lsu_mem_responder #(
  parameter int TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lsu_ren,
  input  logic                       lsu_wen,
  input  logic [1:0]                 lsu_type,
  input  logic [31:0]                lsu_addr_base,
  input  logic [31:0]                lsu_addr_offset,
  input  logic [31:0]                lsu_wdata,
  output logic                       lsu_done,
  output logic [31:0]                lsu_rdata,
  output logic                       lsu_err,
  output logic                       busy,
  lsu_mem_responder_if.master        bus
);

  localparam logic [1:0] TYPE_WORD = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_BYTE = 2'b10;

  // Watchdog counts WAIT cycles 0 .. TIMEOUT-1; the last value ends the access.
  localparam int                CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        type_q, type_d;
  logic [1:0]        lane_q, lane_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0]       lsu_addr;
  logic              type_illegal;
  logic              misaligned;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;

  // Effective byte address wraps modulo 2^32.
  assign lsu_addr     = lsu_addr_base + lsu_addr_offset;
  assign type_illegal = (lsu_type == 2'b11);
  assign misaligned   = ((lsu_type == TYPE_WORD) && (lsu_addr[1:0] != 2'b00)) ||
                        ((lsu_type == TYPE_HALF) && lsu_addr[0]);

  // Byte enables and lane-replicated write data for the incoming request.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    req_be    = 4'b0001 << lsu_addr[1:0];
    req_wdata = {4{lsu_wdata[7:0]}};
    case (lsu_type)
      TYPE_WORD: begin
        req_be    = 4'b1111;
        req_wdata = lsu_wdata;
      end
      TYPE_HALF: begin
        req_be    = 4'b0011 << lsu_addr[1:0];
        req_wdata = {2{lsu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed lane out of a response word and zero-extend it.
  function automatic logic [31:0] extract_read(input logic [1:0]  typ,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
    logic [31:0] res;
    res = word;
    if (typ == TYPE_HALF) begin
      res = {16'h0000, lane[1] ? word[31:16] : word[15:0]};
    end else if (typ == TYPE_BYTE) begin
      case (lane)
        2'd0:    res = {24'h000000, word[7:0]};
        2'd1:    res = {24'h000000, word[15:8]};
        2'd2:    res = {24'h000000, word[23:16]};
        default: res = {24'h000000, word[31:24]};
      endcase
    end
    return res;
  endfunction

  // Next state and next values of every registered output.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    type_d  = type_q;
    lane_d  = lane_q;
    done_d  = 1'b0;
    rdata_d = 32'h0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (lsu_ren || lsu_wen) begin
          if (type_illegal || misaligned) begin
            state_d = ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = {lsu_addr[31:2], 2'b00};
            we_d    = lsu_wen;   // write wins when both are raised
            be_d    = req_be;
            wdata_d = req_wdata;
            type_d  = lsu_type;
            lane_d  = lsu_addr[1:0];
          end
        end
      end
      REQ: begin
        // rvalid is not looked at here, so one coinciding with gnt is dropped.
        if (bus.data_gnt) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          req_d   = 1'b1;
        end
      end
      WAIT: begin
        if (bus.data_rvalid) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = bus.data_err;
          rdata_d = we_q ? 32'h0 : extract_read(type_q, lane_q, bus.data_rdata);
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_MAX)) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; every output is registered and clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset as well, because all outputs must read 0 while reset is held.
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      type_q  <= TYPE_WORD;
      lane_q  <= 2'b00;
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      type_q  <= type_d;
      lane_q  <= lane_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
      cnt_q   <= cnt_d;
    end
  end

  assign lsu_done       = done_q;
  assign lsu_rdata      = rdata_q;
  assign lsu_err        = err_q;
  assign busy           = busy_q;
  assign bus.data_req   = req_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_we    = we_q;
  assign bus.data_be    = be_q;
  assign bus.data_wdata = wdata_q;

endmodule
